// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared result/ROB-id types and default bus sizing for the CDB arbiter
package cdb_arbiter_pkg;
  localparam int WORD_W = 32;
  localparam int ROB_ID_W = 6;
  localparam int CDB_COUNT_DEF = 2;
  localparam int REQ_COUNT_DEF = 4;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;
endpackage

// File: rtl/cdb_rr_picker.sv
// cdb_rr_picker: combinational multi-grant search from a start index, wrapping at REQ_COUNT
module cdb_rr_picker #(
  parameter int REQ_COUNT = 4,
  parameter int CDB_COUNT = 2,
  parameter int IW = 2
) (
  input  logic [REQ_COUNT-1:0]         valid,
  input  logic [IW-1:0]                start,
  output logic [REQ_COUNT-1:0]         grant,
  output logic [CDB_COUNT-1:0]         slot_vld,
  output logic [CDB_COUNT-1:0][IW-1:0] slot_idx,
  output logic [IW-1:0]                last_idx
);
  logic [IW-1:0] idx;
  int cnt;
  // walk every index once from start; the k-th valid one found fills slot k
  always_comb begin
    grant = '0;
    slot_vld = '0;
    slot_idx = '0;
    last_idx = '0;
    idx = start;
    cnt = 0;
    for (int n = 0; n < REQ_COUNT; n++) begin
      for (int k = 0; k < CDB_COUNT; k++)
        if (valid[idx] && cnt == k) begin
          slot_vld[k] = 1'b1;
          slot_idx[k] = idx;
        end
      if (valid[idx] && cnt < CDB_COUNT) begin
        grant[idx] = 1'b1;
        last_idx = idx;
        cnt = cnt + 1;
      end
      idx = (idx == IW'(REQ_COUNT - 1)) ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to CDB_COUNT result FIFOs per cycle onto registered CDB slots; CDB_ARB_RR_EN selects round-robin, otherwise fixed priority
import cdb_arbiter_pkg::*;
module cdb_arbiter #(
  parameter int REQ_COUNT = REQ_COUNT_DEF,
  parameter int CDB_COUNT = CDB_COUNT_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [REQ_COUNT-1:0]               req_valid_i,
  input  logic [REQ_COUNT-1:0][WORD_W-1:0]   req_data_i,
  input  logic [REQ_COUNT-1:0][ROB_ID_W-1:0] req_reg_id_i,
  output logic [REQ_COUNT-1:0]               req_ready_o,
  input  logic                               cdb_ready_i,
  output logic [CDB_COUNT-1:0][WORD_W-1:0]   cdb_data_o,
  output logic [CDB_COUNT-1:0][ROB_ID_W-1:0] cdb_reg_id_o,
  output logic [CDB_COUNT-1:0]               cdb_valid_o
);
  localparam int IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  logic [IW-1:0] start, last_idx;
  logic [REQ_COUNT-1:0] grant;
  logic [CDB_COUNT-1:0] slot_vld;
  logic [CDB_COUNT-1:0][IW-1:0] slot_idx;
  logic eff;
  assign eff = cdb_ready_i & ~flush & rst_n;
  assign req_ready_o = grant & {REQ_COUNT{eff}};
  cdb_rr_picker #(.REQ_COUNT(REQ_COUNT), .CDB_COUNT(CDB_COUNT), .IW(IW)) u_picker (
    .valid(req_valid_i),
    .start(start),
    .grant(grant),
    .slot_vld(slot_vld),
    .slot_idx(slot_idx),
    .last_idx(last_idx)
  );
`ifdef CDB_ARB_RR_EN
  logic [IW-1:0] rr_ptr;
  assign start = rr_ptr;
  // pointer moves just past the last effective winner; flush restarts it at 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (flush) rr_ptr <= '0;
    else if (eff && |grant) rr_ptr <= (last_idx == IW'(REQ_COUNT - 1)) ? '0 : last_idx + 1'b1;
`else
  assign start = '0;
`endif
  // each slot broadcasts for exactly one cycle after an effective grant, zeros otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cdb_valid_o <= '0;
      cdb_data_o <= '0;
      cdb_reg_id_o <= '0;
    end else
      for (int k = 0; k < CDB_COUNT; k++) begin
        cdb_valid_o[k] <= eff & slot_vld[k];
        cdb_data_o[k] <= (eff & slot_vld[k]) ? req_data_i[slot_idx[k]] : '0;
        cdb_reg_id_o[k] <= (eff & slot_vld[k]) ? req_reg_id_i[slot_idx[k]] : '0;
      end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter, expectations for both CDB_ARB_RR_EN builds
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic cdb_ready = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_ready;
  logic [3:0][WORD_W-1:0] req_data;
  logic [3:0][ROB_ID_W-1:0] req_reg_id;
  logic [1:0][WORD_W-1:0] cdb_data;
  logic [1:0][ROB_ID_W-1:0] cdb_reg_id;
  logic [1:0] cdb_valid;
  int checks = 0;
  int fails = 0;
  typedef struct packed {
    logic [1:0] v;
    logic [1:0][WORD_W-1:0] d;
    logic [1:0][ROB_ID_W-1:0] id;
  } exp_t;
  exp_t q[$];

  cdb_arbiter #(.REQ_COUNT(4), .CDB_COUNT(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
    .req_reg_id_i(req_reg_id),
    .req_ready_o(req_ready),
    .cdb_ready_i(cdb_ready),
    .cdb_data_o(cdb_data),
    .cdb_reg_id_o(cdb_reg_id),
    .cdb_valid_o(cdb_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // one cycle of stimulus: hand-computed ready vector and slot winners (-1 = empty) per build
  task automatic step(input logic [3:0] v, input logic r, input logic f,
                      input logic [3:0] rdy_fp, input logic [3:0] rdy_rr,
                      input int f0, input int f1, input int r0, input int r1);
    exp_t e;
    logic [3:0] er;
    int s0, s1;
    @(posedge clk);
    #2;
    req_valid = v;
    cdb_ready = r;
    flush = f;
`ifdef CDB_ARB_RR_EN
    er = rdy_rr; s0 = r0; s1 = r1;
`else
    er = rdy_fp; s0 = f0; s1 = f1;
`endif
    #1 chk("req_ready", 64'(req_ready), 64'(er));
    e = '0;
    if (s0 >= 0) begin
      e.v[0] = 1'b1;
      e.d[0] = WORD_W'(100 + s0);
      e.id[0] = ROB_ID_W'(5 + s0);
    end
    if (s1 >= 0) begin
      e.v[1] = 1'b1;
      e.d[1] = WORD_W'(100 + s1);
      e.id[1] = ROB_ID_W'(5 + s1);
    end
    q.push_back(e);
  endtask

  // monitor: just after each edge the registered CDB reflects the oldest queued expectation
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("cdb_valid", 64'(cdb_valid), 64'(e.v));
      chk("cdb_data", 64'(cdb_data), 64'(e.d));
      chk("cdb_reg_id", 64'(cdb_reg_id), 64'(e.id));
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_data[i] = WORD_W'(100 + i);
      req_reg_id[i] = ROB_ID_W'(5 + i);
    end
    req_valid = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", 64'(cdb_valid), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #2;
    req_valid = '0;
    rst_n = 1'b1;
    //       valid   rdy   fl    rdy_fp  rdy_rr  fp slots  rr slots
    step(4'b1111, 1'b1, 1'b0, 4'b0011, 4'b0011, 0, 1, 0, 1);
    step(4'b1111, 1'b1, 1'b0, 4'b0011, 4'b1100, 0, 1, 2, 3);
    step(4'b1111, 1'b1, 1'b0, 4'b0011, 4'b0011, 0, 1, 0, 1);
    step(4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0100, 2, -1, 2, -1);
    step(4'b1001, 1'b1, 1'b0, 4'b1001, 4'b1001, 0, 3, 3, 0);
    step(4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, -1, -1, -1, -1);
    step(4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, -1, -1, -1, -1);
    step(4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, -1, -1, -1, -1);
    step(4'b1111, 1'b1, 1'b0, 4'b0011, 4'b0110, 0, 1, 1, 2);
    step(4'b1100, 1'b1, 1'b1, 4'b0000, 4'b0000, -1, -1, -1, -1);
    step(4'b1111, 1'b1, 1'b0, 4'b0011, 4'b0011, 0, 1, 0, 1);
    step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, -1, -1, -1, -1);
    step(4'b1111, 1'b1, 1'b0, 4'b0011, 4'b1100, 0, 1, 2, 3);
    step(4'b1111, 1'b1, 1'b0, 4'b0011, 4'b0011, 0, 1, 0, 1);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst_data", 64'(cdb_data), 64'd0);
    chk("async_rst_reg_id", 64'(cdb_reg_id), 64'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares the `CDB_COUNT` common-data-bus broadcast ports among `REQ_COUNT` execution-unit result FIFOs (ALU IQs, LSU, MUL/DIV).
- Each cycle it grants up to `CDB_COUNT` valid requesters in round-robin order. The winners' result and ROB id go into a registered CDB slot.
- The registered slots drive the IQ `cdb_*_i` forwarding inputs and the ROB write ports.
- It sits between the per-unit output FIFOs and the ROB/IQ broadcast network.

## Interface
Parameters:
- `REQ_COUNT`, 4, number of requesting result FIFOs; legal range `CDB_COUNT` ≤ `REQ_COUNT` ≤ 16.
- `CDB_COUNT`, 2, number of broadcast ports.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous pipeline flush.
- `req_valid_i`  in  `REQ_COUNT`  requester holds a result.
- `req_data_i`  in  `word_t[REQ_COUNT]`  result data.
- `req_reg_id_i`  in  `rob_id_t[REQ_COUNT]`  destination ROB id.
- `req_ready_o`  out  `REQ_COUNT`  result accepted this cycle (combinational).
- `cdb_ready_i`  in  1  ROB can accept writes this cycle.
- `cdb_data_o`  out  `word_t[CDB_COUNT]`  broadcast data (registered).
- `cdb_reg_id_o`  out  `rob_id_t[CDB_COUNT]`  broadcast ROB id (registered).
- `cdb_valid_o`  out  `CDB_COUNT`  broadcast slot valid (registered).

## Operation
- `rr_ptr` (`$clog2(REQ_COUNT)` bits) names the highest-priority requester.
- Grant search scans indices `rr_ptr`, `rr_ptr+1`, … and wraps at `REQ_COUNT` back to 0. Wrap uses an explicit compare, so non-power-of-two `REQ_COUNT` is legal.
- The k-th valid requester found gets slot k, for k < `CDB_COUNT`. Further valid requesters wait. Slots fill densely from slot 0.
- `req_ready_o[i]` = granted[i] & `cdb_ready_i` & !`flush`. A requester pops its FIFO exactly when `req_valid_i[i]` & `req_ready_o[i]`.
- A grant is effective only when `cdb_ready_i` is 1 and `flush` is 0.
- Effective grant: next cycle slot k carries the winner's data and reg_id with `cdb_valid_o[k]`=1.
- Unused slots: `cdb_valid_o[k]`=0, data and reg_id are don't-care. The implementation drives 0.
- `cdb_ready_i`=0: no grants and all `req_ready_o`=0. Next cycle all `cdb_valid_o`=0. A broadcast is never held or repeated, because a repeated wakeup is illegal.
- Pointer update on any effective grant: `rr_ptr` ← (index of the last granted requester + 1) mod `REQ_COUNT`. With no effective grant, `rr_ptr` is unchanged.
- `flush`: `req_ready_o`=0 that cycle. On the clock edge, `cdb_valid_o` ← 0 and `rr_ptr` ← 0. Flush takes priority over every grant.
- Reset (async, `rst_n`=0): `cdb_valid_o`=0, `cdb_data_o`=0, `cdb_reg_id_o`=0, `rr_ptr`=0, all immediately.
- Release of reset is synchronized externally; the arbiter resumes on the first edge after release.

## Timing
- Request-to-broadcast latency is exactly 1 cycle: accepted at edge N, visible on the CDB during cycle N+1.
- `req_ready_o` depends combinationally on `req_valid_i`, `rr_ptr`, `cdb_ready_i` and `flush`. There are no other combinational input-to-output paths.
- Sustained throughput is `CDB_COUNT` results per cycle.
- Fairness: with all requesters valid, every requester is granted at least once every ceil(`REQ_COUNT`/`CDB_COUNT`) cycles.
- Reset asserted mid-broadcast clears `cdb_valid_o` asynchronously. Any in-flight result is lost; the flush and recovery path handles this upstream.

## Configuration
- `CDB_ARB_RR_EN` defined: round-robin arbitration with `rr_ptr` as described above.
- `CDB_ARB_RR_EN` undefined: fixed priority, lowest index first (scan always starts at 0). `rr_ptr` is not instantiated. All other behaviour is identical.

## Structure
- `word_t` and `rob_id_t` come from the shared structure package (`a_structure.svh`).
- Shared constants `CDB_COUNT` and `REQ_COUNT` defaults live in the shared defines header beside the IQ defines.
- One sub-module: `cdb_rr_picker`. It is a combinational multi-grant search that outputs the `REQ_COUNT` grant vector, the per-slot winner index and the last-granted index.
- The top level holds `rr_ptr`, the output registers and the handshake gating.

## Test plan
- Reset: hold `rst_n`=0 with `req_valid_i`=4'b1111 -> `cdb_valid_o`=2'b00 and `req_ready_o`=0 throughout. After release, the first grant goes to requesters 0 and 1.
- All valid, `cdb_ready_i`=1, RR enabled, data = 100+i -> grant pairs {0,1},{2,3},{0,1} on successive cycles. `cdb_data_o` = {100,101} one cycle after each {0,1} grant.
- Wrap: `rr_ptr`=3, `req_valid_i`=4'b1001 -> slot0 = requester 3, slot1 = requester 0, and the next `rr_ptr`=1.
- Backpressure: `cdb_ready_i`=0 for 3 cycles with all valid -> `req_ready_o`=0 and `cdb_valid_o`=0 those cycles, `rr_ptr` unchanged. Arbitration resumes from the same pointer afterwards.
- Flush in the same cycle as valid requests from requesters 2 and 3 -> no `req_ready_o`. Next cycle `cdb_valid_o`=0 and `rr_ptr`=0.
- Single requester 2 valid, reg_id 7 -> slot0 valid with reg_id 7 and slot1 invalid. With `CDB_ARB_RR_EN` undefined and all valid, requesters 0 and 1 win every cycle.
